signed_digit_decompose: RTL and testbench

- Sits between the INTT output and the NTT input in the FHEW accumulator loop.
- Takes one beat of LANES coefficients mod Q, centres each coefficient to a signed value, and splits it into DIGITS balanced base-2^LOG_B digits.
- Emits one digit-plane per output beat, least-significant digit first, with each digit re-encoded mod Q for the downstream NTT.

---
 rtl/signed_digit_decompose_pkg.sv | 34 +++
 rtl/signed_digit_decompose_lane.sv | 25 ++
 rtl/signed_digit_decompose.sv | 118 +++++++++++
 tb/tb_signed_digit_decompose.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_digit_decompose_pkg.sv
// Shared sizing, types and the centring helper for the signed digit decomposer.
package signed_digit_decompose_pkg;

  localparam int DATA_W         = 16;
  localparam int LANES          = 8;
  localparam int Q              = 12289;
  localparam int LOG_B          = 3;
  localparam int DIGITS         = 5;
  localparam int BEATS_PER_POLY = 64;

  localparam int B       = 1 << LOG_B;
  localparam int HALF_Q  = (Q - 1) / 2;
  localparam int RES_W   = DATA_W + 1;
  localparam int DIGIT_W = $clog2(DIGITS);
  localparam int BEAT_W  = $clog2(BEATS_PER_POLY);

  typedef logic signed [RES_W-1:0] residual_t;

  typedef enum logic {
    IDLE,
    EMIT
  } state_e;

  // Map a coefficient in [0,Q) onto the symmetric range [-(Q-1)/2, (Q-1)/2].
  function automatic residual_t center(input logic [DATA_W-1:0] x);
    residual_t xe;
    xe = residual_t'({1'b0, x});
    if (x <= DATA_W'(HALF_Q)) begin
      return xe;
    end
    return xe - residual_t'(Q);
  endfunction

endpackage

// File: rtl/signed_digit_decompose_lane.sv
// One lane of digit extraction: balanced low digit, its mod-Q encoding, and
// the residual left for the next digit.
module sdd_lane
  import signed_digit_decompose_pkg::*;
(
  input  residual_t         res_i,
  output logic [DATA_W-1:0] digit_o,
  output residual_t         res_next_o
);

  residual_t d;
  residual_t d_modq;

  // Balanced digit in [-B/2, B/2), re-encoded mod Q, then strip it off the residual.
  always_comb begin
    d = residual_t'({{(RES_W-LOG_B){1'b0}}, res_i[LOG_B-1:0]});
    if (res_i[LOG_B-1]) begin
      d = d - residual_t'(B);
    end
    d_modq     = d[RES_W-1] ? (d + residual_t'(Q)) : d;
    digit_o    = d_modq[DATA_W-1:0];
    res_next_o = (res_i - d) >>> LOG_B;
  end

endmodule

// File: rtl/signed_digit_decompose.sv
// Signed digit decomposer: centres each lane mod Q and emits DIGITS balanced
// base-B digit-planes per input beat, least-significant digit first.
module signed_digit_decompose
  import signed_digit_decompose_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic [DIGIT_W-1:0]      out_digit,
  output logic                    out_poly_last,
  output logic                    ovf
);

  state_e              state_q, state_d;
  logic [DIGIT_W-1:0]  digit_q, digit_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic                ovf_q, ovf_d;
  residual_t           res_q    [LANES];
  residual_t           res_d    [LANES];
  residual_t           res_next [LANES];

  logic plane_accept;
  logic last_digit;
  logic last_beat;
  logic capture;
  logic any_nonzero;

  assign out_valid     = (state_q == EMIT);
  assign last_digit    = (digit_q == DIGIT_W'(DIGITS - 1));
  assign last_beat     = (beat_q == BEAT_W'(BEATS_PER_POLY - 1));
  assign plane_accept  = out_valid & out_ready;
  assign in_ready      = (state_q == IDLE) | (plane_accept & last_digit);
  assign capture       = in_valid & in_ready;
  assign out_digit     = digit_q;
  assign out_poly_last = out_valid & last_digit & last_beat;
  assign ovf           = ovf_q;

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      sdd_lane u_lane (
        .res_i      (res_q[g]),
        .digit_o    (out_data[g*DATA_W +: DATA_W]),
        .res_next_o (res_next[g])
      );
    end
  endgenerate

  // Flag any lane whose residual is still nonzero after stripping the current digit.
  always_comb begin
    any_nonzero = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      any_nonzero = any_nonzero | (res_next[i] != '0);
    end
  end

  // Next-state: advance residuals on accept, close a beat on its last digit, capture new beats.
  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    beat_d  = beat_q;
    ovf_d   = ovf_q;
    for (int i = 0; i < LANES; i++) begin
      res_d[i] = res_q[i];
    end

    if (plane_accept) begin
      for (int i = 0; i < LANES; i++) begin
        res_d[i] = res_next[i];
      end
      if (last_digit) begin
        digit_d = '0;
        state_d = IDLE;
        beat_d  = last_beat ? '0 : beat_q + 1'b1;
        if (any_nonzero) begin
          ovf_d = 1'b1;
        end
      end else begin
        digit_d = digit_q + 1'b1;
      end
    end

    if (capture) begin
      for (int i = 0; i < LANES; i++) begin
        res_d[i] = center(in_data[i*DATA_W +: DATA_W]);
      end
      state_d = EMIT;
      digit_d = '0;
    end
  end

  // State, counters, sticky overflow and residual registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      digit_q <= '0;
      beat_q  <= '0;
      ovf_q   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        res_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      beat_q  <= beat_d;
      ovf_q   <= ovf_d;
      for (int i = 0; i < LANES; i++) begin
        res_q[i] <= res_d[i];
      end
    end
  end

endmodule

// File: tb/tb_signed_digit_decompose.sv
// Self-checking bench for signed_digit_decompose using a plane scoreboard.
module tb_signed_digit_decompose;
  import signed_digit_decompose_pkg::*;

  localparam int PW = LANES * DATA_W;

  typedef logic [PW-1:0] plane_t;
  typedef plane_t planes_t [DIGITS];
  typedef struct packed {
    plane_t             data;
    logic [DIGIT_W-1:0] digit;
    logic               last;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in_valid;
  logic               in_ready;
  plane_t             in_data;
  logic               out_valid;
  logic               out_ready;
  plane_t             out_data;
  logic [DIGIT_W-1:0] out_digit;
  logic               out_poly_last;
  logic               ovf;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  int beat_model = 0;

  plane_t             prev_data;
  logic [DIGIT_W-1:0] prev_digit;
  logic               prev_last;
  bit                 prev_stall = 0;
  int                 run_len = 0;
  int                 max_run = 0;
  int                 pl_count = 0;

  signed_digit_decompose dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_digit     (out_digit),
    .out_poly_last (out_poly_last),
    .ovf           (ovf)
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: pops an expected plane on every accepted output plane.
  always @(negedge clk) begin
    if (!reset_n) begin
      prev_stall = 0;
      run_len    = 0;
    end else begin
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
        if (out_poly_last) pl_count++;
        checks++;
        if (in_ready !== (out_ready && (out_digit == DIGIT_W'(DIGITS - 1)))) begin
          errors++;
          $display("[TB] FAIL in_ready_rule: got %0b with out_ready=%0b digit=%0d", in_ready, out_ready, out_digit);
        end
        if (prev_stall) begin
          checks++;
          if (out_data !== prev_data || out_digit !== prev_digit || out_poly_last !== prev_last) begin
            errors++;
            $display("[TB] FAIL stall_hold: got digit %0d data %h, held digit %0d data %h", out_digit, out_data, prev_digit, prev_data);
          end
        end
        if (out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_plane: got digit %0d data %h, expected no plane", out_digit, out_data);
          end else begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (out_data !== e.data) begin
              errors++;
              $display("[TB] FAIL plane_data: got %h expected %h (digit %0d)", out_data, e.data, e.digit);
            end
            checks++;
            if (out_digit !== e.digit) begin
              errors++;
              $display("[TB] FAIL plane_digit: got %0d expected %0d", out_digit, e.digit);
            end
            checks++;
            if (out_poly_last !== e.last) begin
              errors++;
              $display("[TB] FAIL poly_last: got %0b expected %0b", out_poly_last, e.last);
            end
          end
        end
      end else begin
        run_len = 0;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_digit = out_digit;
      prev_last  = out_poly_last;
    end
  end

  // Reference decomposition done with plain integer arithmetic.
  task automatic model_planes(input plane_t data, output planes_t p);
    for (int k = 0; k < DIGITS; k++) p[k] = '0;
    for (int l = 0; l < LANES; l++) begin
      int x;
      int r;
      x = int'(data[l*DATA_W +: DATA_W]);
      r = (x > (Q - 1) / 2) ? x - Q : x;
      for (int k = 0; k < DIGITS; k++) begin
        int m;
        int d;
        m = ((r % B) + B) % B;
        d = (m >= B / 2) ? m - B : m;
        p[k][l*DATA_W +: DATA_W] = DATA_W'((d < 0) ? d + Q : d);
        r = (r - d) / B;
      end
    end
  endtask

  function automatic plane_t lane01(input int a, input int b);
    plane_t p;
    p = '0;
    p[0 +: DATA_W]      = DATA_W'(a);
    p[DATA_W +: DATA_W] = DATA_W'(b);
    return p;
  endfunction

  task automatic push_beat(input planes_t p);
    for (int k = 0; k < DIGITS; k++) begin
      exp_t e;
      e.data  = p[k];
      e.digit = DIGIT_W'(k);
      e.last  = (k == DIGITS - 1) && (beat_model == BEATS_PER_POLY - 1);
      sb.push_back(e);
    end
    beat_model = (beat_model == BEATS_PER_POLY - 1) ? 0 : beat_model + 1;
  endtask

  task automatic send_beat(input plane_t data, input planes_t p);
    int waited;
    bit done;
    waited   = 0;
    done     = 0;
    in_data  = data;
    in_valid = 1'b1;
    while (!done && waited < 200) begin
      @(negedge clk);
      if (in_ready) begin
        push_beat(p);
        done = 1;
      end else begin
        waited++;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout: in_ready got 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 400) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d planes pending expected 0", sb.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n  = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    beat_model = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #2;
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_digit !== '0 || out_poly_last !== 1'b0 || ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%0b data=%h digit=%0d last=%0b ovf=%0b expected all 0", out_valid, out_data, out_digit, out_poly_last, ovf);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    planes_t p;
    p[0] = lane01(12285, 0);
    p[1] = lane01(12286, 0);
    p[2] = lane01(2, 0);
    p[3] = lane01(0, 0);
    p[4] = lane01(0, 0);
    out_ready = 1'b1;
    send_beat(lane01(100, 0), p);
    for (int k = 0; k < DIGITS; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_digit !== DIGIT_W'(k)) begin
        errors++;
        $display("[TB] FAIL single_timing: got valid=%0b digit=%0d expected valid=1 digit=%0d", out_valid, out_digit, k);
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_idle: got out_valid=%0b expected 0", out_valid);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_ovf: got %0b expected 0", ovf);
    end
  endtask

  task automatic test_minus_one_and_boundary();
    planes_t p;
    p[0] = lane01(12288, 0);
    for (int k = 1; k < DIGITS; k++) p[k] = lane01(0, 0);
    send_beat(lane01(12288, 0), p);
    wait_drain();
    p[0] = lane01(0, 0);
    p[1] = lane01(0, 0);
    p[2] = lane01(0, 0);
    p[3] = lane01(12285, 12285);
    p[4] = lane01(2, 12288);
    send_beat(lane01(6144, 6145), p);
    wait_drain();
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    plane_t d1, d2;
    planes_t p1, p2;
    pat = 4'b1001;
    for (int l = 0; l < LANES; l++) begin
      d1[l*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, Q - 1));
      d2[l*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, Q - 1));
    end
    model_planes(d1, p1);
    model_planes(d2, p2);
    fork
      begin
        send_beat(d1, p1);
        send_beat(d2, p2);
      end
      begin
        for (int i = 0; i < 48; i++) begin
          out_ready = pat[i % 4];
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    wait_drain();
  endtask

  task automatic test_back_to_back();
    plane_t d;
    planes_t p;
    do_reset();
    out_ready = 1'b1;
    max_run  = 0;
    pl_count = 0;
    for (int b = 0; b < BEATS_PER_POLY; b++) begin
      for (int l = 0; l < LANES; l++) d[l*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, Q - 1));
      model_planes(d, p);
      send_beat(d, p);
    end
    wait_drain();
    checks++;
    if (max_run != BEATS_PER_POLY * DIGITS) begin
      errors++;
      $display("[TB] FAIL stream_no_bubble: got run of %0d planes expected %0d", max_run, BEATS_PER_POLY * DIGITS);
    end
    checks++;
    if (pl_count != 1) begin
      errors++;
      $display("[TB] FAIL stream_poly_last_count: got %0d expected 1", pl_count);
    end
    for (int l = 0; l < LANES; l++) d[l*DATA_W +: DATA_W] = DATA_W'($urandom_range(0, Q - 1));
    model_planes(d, p);
    send_beat(d, p);
    wait_drain();
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stream_ovf: got %0b expected 0", ovf);
    end
  endtask

  task automatic test_reset_mid();
    planes_t p;
    p[0] = lane01(12285, 0);
    p[1] = lane01(12286, 0);
    p[2] = lane01(2, 0);
    p[3] = lane01(0, 0);
    p[4] = lane01(0, 0);
    out_ready = 1'b1;
    send_beat(lane01(100, 0), p);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (out_digit !== 3'd2) begin
      errors++;
      $display("[TB] FAIL mid_digit: got %0d expected 2", out_digit);
    end
    reset_n = 1'b0;
    sb.delete();
    beat_model = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_digit !== '0 || out_poly_last !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_reset_clear: got valid=%0b data=%h digit=%0d expected all 0", out_valid, out_data, out_digit);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL mid_release: got in_ready=%0b out_valid=%0b expected 1 and 0", in_ready, out_valid);
    end
    p[0] = lane01(12288, 0);
    for (int k = 1; k < DIGITS; k++) p[k] = lane01(0, 0);
    send_beat(lane01(12288, 0), p);
    checks++;
    if (out_digit !== '0 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_restart: got digit=%0d valid=%0b expected 0 and 1", out_digit, out_valid);
    end
    wait_drain();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_minus_one_and_boundary();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
